// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit frame sequencer and its bench model.
// Holds the sequencer state encoding, frame widths, CRC defaults and the bit interleaver.
package tx_pkg;

    localparam int PAYLOAD_W = 32;
    localparam int CRC_W     = 16;
    localparam int MSG_W     = PAYLOAD_W + CRC_W;
    localparam int FRAME_W   = 2 * MSG_W;

    localparam logic [CRC_W-1:0] CRC_POLY_DEF = 16'h8005;
    localparam logic [CRC_W-1:0] CRC_INIT_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        CRC,
        ENC,
        DONE
    } state_t;

    // Byte n supplies bit pair j to group j; byte 11 lands in the top pair of every group.
    function automatic logic [FRAME_W-1:0] interleave(input logic [FRAME_W-1:0] enc);
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int j = 0; j < 4; j++) begin
            for (int n = 0; n < 12; n++) begin
                f[72 - 24*j + 2*n +: 2] = enc[88 - 8*n + 2*j +: 2];
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/conv_enc_r12.sv
// Rate-1/2 convolutional encoder core: 3-bit shift state, combinational parity pair.
// Zero latency on p0/p1; state advances only when enabled, clear forces the zero state.
module conv_enc_r12 (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_bit,
    output logic o_p0,
    output logic o_p1
);

    logic [2:0] r_s;

    assign o_p0 = i_bit ^ r_s[0] ^ r_s[1] ^ r_s[2];
    assign o_p1 = i_bit ^ r_s[1] ^ r_s[2];

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_s <= 3'd0;
        end else if (i_en) begin
            r_s <= {r_s[1:0], i_bit};
        end
    end

endmodule

// File: rtl/tx_frame_sequencer.sv
// Payload -> CRC-16 -> rate-1/2 FEC -> interleave; accept to out_valid is 81 cycles.
// Single frame in flight: in_ready only in IDLE, finished frame held until out_ready or abort.
module tx_frame_sequencer
    import tx_pkg::*;
#(
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_POLY_DEF,
    parameter logic [CRC_W-1:0] CRC_INIT = CRC_INIT_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [PAYLOAD_W-1:0] i_in_data,
    input  logic                 i_abort,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [FRAME_W-1:0]   o_out_frame,
    output logic [CRC_W-1:0]     o_crc_out,
    output logic                 o_busy,
    output logic [7:0]           o_frame_count
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MSG_W-1:0]   r_msg;
    logic [CRC_W-1:0]   r_crc;
    logic [FRAME_W-1:0] r_enc;
    logic [5:0]         r_cnt;
    logic [7:0]         r_frame_count;

    logic               w_accept;
    logic               w_deliver;
    logic               w_crc_last;
    logic               w_enc_last;
    logic               w_bit;
    logic               w_fb;
    logic [CRC_W-1:0]   w_crc_nxt;
    logic               w_enc_clr;
    logic               w_enc_en;
    logic               w_p0;
    logic               w_p1;

    // r_msg[47] is the current serial bit in both CRC and ENC phases.
    assign w_bit      = r_msg[MSG_W-1];
    assign w_fb       = w_bit ^ r_crc[CRC_W-1];
    assign w_crc_nxt  = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);
    assign w_crc_last = (r_cnt == 6'd31);
    assign w_enc_last = (r_cnt == 6'd47);
    assign w_enc_clr  = (r_state == CRC) && (w_state_nxt == ENC);
    assign w_enc_en   = (r_state == ENC) && !i_abort;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_deliver   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_in_valid && !i_abort) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CRC;
                end
            end
            CRC: begin
                if (i_abort)         w_state_nxt = IDLE;
                else if (w_crc_last) w_state_nxt = ENC;
            end
            ENC: begin
                if (i_abort)         w_state_nxt = IDLE;
                else if (w_enc_last) w_state_nxt = DONE;
            end
            DONE: begin
                if (i_abort) begin
                    w_state_nxt = IDLE;
                end else if (i_out_ready) begin
                    w_deliver   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_msg         <= '0;
            r_crc         <= '0;
            r_enc         <= '0;
            r_cnt         <= '0;
            r_frame_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_msg <= {i_in_data, {CRC_W{1'b0}}};
                r_crc <= CRC_INIT;
                r_cnt <= '0;
            end else if (r_state == CRC && !i_abort) begin
                // Rotate the payload so it is intact again when the CRC is appended.
                r_msg[MSG_W-1:CRC_W] <= {r_msg[MSG_W-2:CRC_W], r_msg[MSG_W-1]};
                r_crc                <= w_crc_nxt;
                if (w_crc_last) begin
                    r_msg[CRC_W-1:0] <= w_crc_nxt;
                    r_cnt            <= '0;
                end else begin
                    r_cnt <= r_cnt + 6'd1;
                end
            end else if (r_state == ENC && !i_abort) begin
                r_msg <= {r_msg[MSG_W-2:0], 1'b0};
                r_enc <= {r_enc[FRAME_W-3:0], w_p1, w_p0};
                r_cnt <= w_enc_last ? 6'd0 : r_cnt + 6'd1;
            end
            if (w_deliver) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    conv_enc_r12 u_enc (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_enc_clr),
        .i_en    (w_enc_en),
        .i_bit   (w_bit),
        .o_p0    (w_p0),
        .o_p1    (w_p1)
    );

    assign o_in_ready    = (r_state == IDLE);
    assign o_busy        = (r_state != IDLE);
    assign o_out_valid   = (r_state == DONE);
    assign o_out_frame   = interleave(r_enc);
    assign o_crc_out     = r_crc;
    assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Scoreboard bench for tx_frame_sequencer: driver pushes expected frames, monitor pops on handshake.
module tb_tx_frame_sequencer;
    import tx_pkg::*;

    localparam logic [95:0] FRAME_ZERO = 96'hD00000_700000_000000_C00000;
    localparam logic [15:0] CRC_ZERO   = 16'h0024;

    logic        i_clk;
    logic        i_reset;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_in_data;
    logic        i_abort;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [95:0] o_out_frame;
    logic [15:0] o_crc_out;
    logic        o_busy;
    logic [7:0]  o_frame_count;

    typedef struct {
        logic [95:0] frame;
        logic [15:0] crc;
        int          acc_edge;
        bit          chk_lat;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         ready_mode = 0;
    logic [7:0] exp_count = 8'd0;

    tx_frame_sequencer dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_in_valid    (i_in_valid),
        .o_in_ready    (o_in_ready),
        .i_in_data     (i_in_data),
        .i_abort       (i_abort),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_out_frame   (o_out_frame),
        .o_crc_out     (o_crc_out),
        .o_busy        (o_busy),
        .o_frame_count (o_frame_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_crc16(input logic [31:0] d);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 31; i >= 0; i--) begin
            fb = d[i] ^ c[15];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
        end
        return c;
    endfunction

    function automatic logic [95:0] m_encode(input logic [47:0] m);
        logic [95:0] e;
        logic [2:0]  s;
        logic        b;
        e = '0;
        s = 3'b000;
        for (int k = 0; k < 48; k++) begin
            b = m[47-k];
            e[95-2*k] = b ^ s[1] ^ s[2];
            e[94-2*k] = b ^ s[0] ^ s[1] ^ s[2];
            s = {s[1], s[0], b};
        end
        return e;
    endfunction

    // Output bit o comes from group g = 3 - o/24, byte n and pair offset t within it.
    function automatic logic [95:0] m_interleave(input logic [95:0] e);
        logic [95:0] f;
        int g, r, n, t;
        for (int o = 0; o < 96; o++) begin
            g = 3 - o / 24;
            r = o % 24;
            n = r / 2;
            t = r % 2;
            f[o] = e[88 - 8*n + 2*g + t];
        end
        return f;
    endfunction

    function automatic logic [95:0] m_frame(input logic [31:0] d);
        return m_interleave(m_encode({d, m_crc16(d)}));
    endfunction

    initial begin
        i_out_ready = 1'b1;
        forever begin
            @(negedge i_clk);
            #1;
            case (ready_mode)
                0:       i_out_ready = 1'b1;
                1:       i_out_ready = 1'($urandom_range(0, 1));
                default: i_out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        logic        prev_stall;
        logic [95:0] prev_frame;
        exp_t        e;
        int          hs_edge;
        prev_stall = 1'b0;
        prev_frame = '0;
        forever begin
            @(negedge i_clk);
            #3;
            if (i_reset) begin
                exp_count  = 8'd0;
                prev_stall = 1'b0;
            end else begin
                check("in_ready_vs_busy", o_in_ready, !o_busy);
                if (o_out_valid && prev_stall) check("frame_stable", o_out_frame, prev_frame);
                if (o_out_valid && i_out_ready && !i_abort) begin
                    hs_edge = cyc + 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame actual=%0h expected=none", o_out_frame);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_frame", o_out_frame, e.frame);
                        check("crc_out", o_crc_out, e.crc);
                        check("frame_count_at_hs", o_frame_count, exp_count);
                        if (e.chk_lat) check("latency", hs_edge - e.acc_edge, 81);
                    end
                    exp_count  = exp_count + 8'd1;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = o_out_valid && !i_abort;
                    prev_frame = o_out_frame;
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit push, input logic [95:0] ef,
                        input logic [15:0] ec, output int acc);
        int   n;
        exp_t e;
        acc = -1;
        n = 0;
        i_in_valid = 1'b1;
        i_in_data  = d;
        while (acc < 0 && n < 400) begin
            #3;
            if (o_in_ready && !i_abort && !i_reset) begin
                acc = cyc + 1;
                if (push) begin
                    e.frame    = ef;
                    e.crc      = ec;
                    e.acc_edge = acc;
                    e.chk_lat  = (ready_mode == 0);
                    exp_q.push_back(e);
                end
            end
            @(negedge i_clk);
            n++;
        end
        i_in_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_accept expected=accept");
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
        end
        repeat (2) @(negedge i_clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, o_in_ready, 1'b1);
        check({tag, "_out_valid"}, o_out_valid, 1'b0);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_out_frame"}, o_out_frame, 96'h0);
        check({tag, "_crc_out"}, o_crc_out, 16'h0);
        check({tag, "_frame_count"}, o_frame_count, 8'h0);
    endtask

    initial begin
        int          a0, a_prev, n;
        logic [31:0] d;
        i_reset    = 1'b1;
        i_in_valid = 1'b0;
        i_in_data  = '0;
        i_abort    = 1'b0;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        check_reset_state("por");

        // All-zero payload with zero-wait downstream.
        ready_mode = 0;
        send(32'h0, 1'b1, FRAME_ZERO, CRC_ZERO, a0);
        wait_drain();
        check("zero_crc_hold", o_crc_out, CRC_ZERO);
        check("zero_count", o_frame_count, 8'd1);

        // Random payloads with random downstream stalls.
        ready_mode = 1;
        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            send(d, 1'b1, m_frame(d), m_crc16(d), a0);
        end
        wait_drain();
        ready_mode = 0;
        repeat (2) @(negedge i_clk);
        check("rand_count", o_frame_count, 8'd11);

        // Abort in ENC at accept + 40, then a clean zero frame.
        send(32'hDEADBEEF, 1'b0, '0, '0, a0);
        repeat (39) @(negedge i_clk);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check("abort_enc_busy", o_busy, 1'b0);
        check("abort_enc_valid", o_out_valid, 1'b0);
        check("abort_enc_count", o_frame_count, 8'd11);
        send(32'h0, 1'b1, FRAME_ZERO, CRC_ZERO, a0);
        wait_drain();
        check("after_abort_count", o_frame_count, 8'd12);

        // Synchronous reset at accept + 20.
        send(32'h12345678, 1'b0, '0, '0, a0);
        repeat (19) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        check_reset_state("midrst");

        // Held in DONE; in_valid while busy ignored; abort beats out_ready.
        ready_mode = 2;
        send(32'hCAFEF00D, 1'b0, '0, '0, a0);
        i_in_valid = 1'b1;
        i_in_data  = 32'h5555AAAA;
        repeat (20) @(negedge i_clk);
        check("busy_in_ready", o_in_ready, 1'b0);
        i_in_valid = 1'b0;
        n = 0;
        while (!o_out_valid && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check("done_reached", o_out_valid, 1'b1);
        repeat (3) @(negedge i_clk);
        check("done_in_ready", o_in_ready, 1'b0);
        ready_mode = 0;
        i_abort    = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check("abort_done_busy", o_busy, 1'b0);
        check("abort_done_valid", o_out_valid, 1'b0);
        check("abort_done_count", o_frame_count, 8'd0);
        repeat (2) @(negedge i_clk);
        check("abort_done_quiet", o_out_valid, 1'b0);

        // 256 back-to-back frames from a clean count: wrap to 0, 82-cycle spacing.
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        a_prev = 0;
        for (int i = 0; i < 256; i++) begin
            d = (i * 32'h01010101) ^ 32'hA5C3_3C5A;
            send(d, 1'b1, m_frame(d), m_crc16(d), a0);
            if (i > 0) check("spacing", a0 - a_prev, 82);
            a_prev = a0;
        end
        wait_drain();
        check("wrap_count", o_frame_count, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
